wb_skid_reg: RTL and testbench

Parametrised successor of the MEM/WB pipeline register. It is a two-entry skid-buffered stage that carries rd, regwe and write-back data with a valid/ready handshake on both sides, plus a synchronous flush and x0-write suppression. It sits between the MEM stage and the register-file write port, so MEM no longer stalls combinationally when write-back back-pressures.

---
 rtl/wb_skid_reg_pkg.sv | 21 ++
 rtl/wb_slot.sv | 19 +
 rtl/wb_skid_reg.sv | 132 +++++++++++++
 tb/tb_wb_skid_reg.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_skid_reg_pkg.sv
// Shared constants, state encodings and helpers for the MEM/WB skid register.
package wb_skid_reg_pkg;

    localparam int   REG_BUS_W  = 32;
    localparam int   REG_ADDR_W = 5;
    localparam logic ENABLED    = 1'b1;
    localparam logic DISABLED   = 1'b0;

    typedef enum logic [1:0] {
        WB_EMPTY = 2'b00,
        WB_ONE   = 2'b01,
        WB_FULL  = 2'b10
    } wb_state_e;

    // Write enable seen by the register file; zs blocks writes to x0.
    function automatic logic qualify_we(input logic valid, input logic we,
                                        input logic rd_nz, input logic zs);
        return valid & we & (rd_nz | ~zs);
    endfunction

endpackage

// File: rtl/wb_slot.sv
// Payload register with synchronous clear and load enable.
module wb_slot #(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (ld)
            q <= d;
    end

endmodule

// File: rtl/wb_skid_reg.sv
// Two-entry skid-buffered MEM/WB stage with flush and x0-write suppression.
// Optional WB_SKID_PERF_EN adds a saturating write-back stall counter.
module wb_skid_reg
    import wb_skid_reg_pkg::*;
#(
    parameter int DATA_W        = REG_BUS_W,
    parameter int ADDR_W        = REG_ADDR_W,
    parameter int ZERO_SUPPRESS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd,
    input  logic              regwe,
    input  logic [DATA_W-1:0] wbdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] rd_o,
    output logic              regwe_o,
    output logic [DATA_W-1:0] wbdata_o
`ifdef WB_SKID_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int PW = ADDR_W + 1 + DATA_W;

    wb_state_e   state, state_nxt;
    logic        accept, consume;
    logic        main_ld, skid_ld, main_from_skid;
    logic        main_we;
    logic [PW-1:0] in_pl, main_d, main_q, skid_q;

    assign in_pl     = {rd, regwe, wbdata};
    assign out_valid = (state != WB_EMPTY);
    assign in_ready  = (state != WB_FULL);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst == ENABLED)
            state <= WB_EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_nxt = WB_EMPTY;
        end else begin
            case (state)
                WB_EMPTY: begin
                    if (accept) begin
                        state_nxt = WB_ONE;
                        main_ld   = 1'b1;
                    end
                end
                WB_ONE: begin
                    if (accept && consume) begin
                        main_ld = 1'b1;
                    end else if (accept) begin
                        state_nxt = WB_FULL;
                        skid_ld   = 1'b1;
                    end else if (consume) begin
                        state_nxt = WB_EMPTY;
                    end
                end
                WB_FULL: begin
                    // Skid payload is left stale; state alone marks it invalid.
                    if (consume) begin
                        state_nxt      = WB_ONE;
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_nxt = WB_EMPTY;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_pl;

    wb_slot #(.W(PW)) u_main (
        .clk (clk),
        .clr (rst),
        .ld  (main_ld),
        .d   (main_d),
        .q   (main_q)
    );

    wb_slot #(.W(PW)) u_skid (
        .clk (clk),
        .clr (rst),
        .ld  (skid_ld),
        .d   (in_pl),
        .q   (skid_q)
    );

    assign {rd_o, main_we, wbdata_o} = main_q;
    assign regwe_o = out_valid ? qualify_we(out_valid, main_we, rd_o != '0, ZERO_SUPPRESS != 0)
                               : DISABLED;

`ifdef WB_SKID_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            perf_stall_cnt <= '0;
        else if (out_valid && !out_ready && perf_stall_cnt != 32'hFFFF_FFFF)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
`endif

`ifndef SYNTHESIS
    // A rejected entry must be presented unchanged until it is accepted.
    logic          hold_q;
    logic [PW-1:0] hold_pl;
    always_ff @(posedge clk) begin
        hold_q  <= in_valid & ~in_ready & ~rst & ~flush;
        hold_pl <= in_pl;
        if (hold_q && !rst && !flush)
            assert (in_valid && in_pl == hold_pl)
                else $error("wb_skid_reg: upstream changed a held entry");
    end
`endif

endmodule

// File: tb/tb_wb_skid_reg.sv
// Directed bench for wb_skid_reg with an output scoreboard; second instance has ZERO_SUPPRESS=0.
module tb_wb_skid_reg;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, regwe, out_ready;
    logic [4:0]  rd;
    logic [31:0] wbdata;
    logic        in_ready, out_valid, regwe_o;
    logic [4:0]  rd_o;
    logic [31:0] wbdata_o;
    logic        in_ready1, out_valid1, regwe_o1;
    logic [4:0]  rd_o1;
    logic [31:0] wbdata_o1;
`ifdef WB_SKID_PERF_EN
    logic [31:0] perf0, perf1;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    wb_skid_reg #(.DATA_W(32), .ADDR_W(5), .ZERO_SUPPRESS(1)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .rd(rd), .regwe(regwe), .wbdata(wbdata), .out_valid(out_valid), .out_ready(out_ready),
        .rd_o(rd_o), .regwe_o(regwe_o), .wbdata_o(wbdata_o)
`ifdef WB_SKID_PERF_EN
        , .perf_stall_cnt(perf0)
`endif
    );

    wb_skid_reg #(.DATA_W(32), .ADDR_W(5), .ZERO_SUPPRESS(0)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .rd(rd), .regwe(regwe), .wbdata(wbdata), .out_valid(out_valid1), .out_ready(out_ready),
        .rd_o(rd_o1), .regwe_o(regwe_o1), .wbdata_o(wbdata_o1)
`ifdef WB_SKID_PERF_EN
        , .perf_stall_cnt(perf1)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd_o"}, 64'(rd_o), 64'd0);
        chk({tag, "_regwe_o"}, 64'(regwe_o), 64'd0);
        chk({tag, "_wbdata_o"}, 64'(wbdata_o), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    // Scoreboard: push on accept, pop and compare on consume; flush/reset drop all.
    always @(negedge clk) begin
        exp_t e;
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_rd", 64'(rd_o), 64'(e.rd));
                    chk("sb_data", 64'(wbdata_o), 64'(e.data));
                    chk("sb_we", 64'(regwe_o), 64'(e.we));
                end
            end
            if (in_valid && in_ready)
                sb.push_back('{rd, wbdata, regwe && (rd != 5'd0)});
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; regwe = 1'b0;
        out_ready = 1'b0; rd = '0; wbdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

`ifdef WB_SKID_PERF_EN
        in_valid = 1'b1; rd = 5'd1; regwe = 1'b1; wbdata = 32'h55;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        @(negedge clk);
        chk("perf_10", 64'(perf0), 64'd10);
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("perf_after_flush", 64'(perf0), 64'd10);
        chk("perf_flush_empty", 64'(out_valid), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("perf_rst", 64'(perf0), 64'd0);
`endif

        // streaming
        out_ready = 1'b1; in_valid = 1'b1; regwe = 1'b1; rd = 5'd3; wbdata = 32'h11;
        step();
        rd = 5'd4; wbdata = 32'h22;
        @(negedge clk);
        chk("stream_valid", 64'(out_valid), 64'd1);
        chk("stream_rd3", 64'(rd_o), 64'd3);
        chk("stream_we", 64'(regwe_o), 64'd1);
        chk("stream_rdy0", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_rd4", 64'(rd_o), 64'd4);
        chk("stream_rdy1", 64'(in_ready), 64'd1);
        step();
        @(negedge clk);
        chk("stream_drain", 64'(out_valid), 64'd0);

        // back-pressure to FULL, then drain
        out_ready = 1'b0; in_valid = 1'b1; rd = 5'd5; wbdata = 32'hAA;
        step();
        rd = 5'd6; wbdata = 32'hBB;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_rd_a", 64'(rd_o), 64'd5);
        chk("full_data_a", 64'(wbdata_o), 64'hAA);
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("full_rd_b", 64'(rd_o), 64'd6);
        chk("full_rdy_back", 64'(in_ready), 64'd1);
        step();
        @(negedge clk);
        chk("full_empty", 64'(out_valid), 64'd0);
        chk("full_sb_empty", 64'(sb.size()), 64'd0);

        // flush in FULL with a new entry presented
        out_ready = 1'b0; in_valid = 1'b1; rd = 5'd8; wbdata = 32'hCC;
        step();
        rd = 5'd9; wbdata = 32'hDD;
        step();
        @(negedge clk);
        chk("pre_flush_full", 64'(in_ready), 64'd0);
        rd = 5'd7; wbdata = 32'h77; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_we", 64'(regwe_o), 64'd0);
        chk("flush_rdy", 64'(in_ready), 64'd1);
        chk("flush_payload_kept", 64'(rd_o), 64'd8);
        out_ready = 1'b1;
        repeat (2) step();
        @(negedge clk);
        chk("flush_no_emerge", 64'(out_valid), 64'd0);

        // reset while FULL
        out_ready = 1'b0; in_valid = 1'b1; rd = 5'd10; wbdata = 32'h1010;
        step();
        rd = 5'd11; wbdata = 32'h1111;
        step();
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");

        // x0 write suppression
        in_valid = 1'b1; rd = 5'd0; regwe = 1'b1; wbdata = 32'hDEAD;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("x0_valid", 64'(out_valid), 64'd1);
        chk("x0_we_zs1", 64'(regwe_o), 64'd0);
        chk("x0_data", 64'(wbdata_o), 64'hDEAD);
        chk("x0_we_zs0", 64'(regwe_o1), 64'd1);
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("x0_drain", 64'(out_valid), 64'd0);
        chk("x0_drain_zs0_we", 64'(regwe_o1), 64'd0);

        chk("sb_final_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
